// File: rtl/if_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
package if_pkg;

  localparam int unsigned IF_AW = 32;
  localparam int unsigned IF_IW = 32;

  localparam logic [6:0]       B_OPC = 7'b1100000;
  localparam logic [IF_IW-1:0] NOP   = 32'hC800_0000;

  typedef struct packed {
    logic [IF_AW-1:0] pc;
    logic [IF_IW-1:0] instr;
  } fq_entry_t;

  // Relative word-offset target, wrapping modulo 2^IF_AW.
  function automatic logic [IF_AW-1:0] br_target(input logic [IF_AW-1:0] base,
                                                 input logic [15:0]      off16);
    return base + {{(IF_AW-18){off16[15]}}, off16, 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_queue.sv
// Small FIFO of fetched {pc, instr} entries; pointers carry an extra wrap bit.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  fq_entry_t                i_push_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output fq_entry_t                o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PW = $clog2(DEPTH);

  fq_entry_t  r_mem [DEPTH];
  logic [PW:0] r_wptr;
  logic [PW:0] r_rptr;

  // Flush discards everything still queued, including a same-cycle push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_rptr <= r_wptr;
    end else begin
      if (i_push) r_wptr <= r_wptr + (PW+1)'(1);
      if (i_pop)  r_rptr <= r_rptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wptr[PW-1:0]] <= i_push_data;
  end

  assign o_head  = r_mem[r_rptr[PW-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign o_count = r_wptr - r_rptr;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, 1-cycle IM fetch, fetch queue, local B and redirects.
// Build option: define IF_PERF_CNT_EN to include the perf_fetch/perf_flush counters.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int unsigned    IW       = IF_IW,
  parameter int unsigned    AW       = IF_AW,
  parameter int unsigned    FQ_DEPTH = 2,
  parameter logic [AW-1:0]  RESET_PC = '0,
  parameter logic [IW-1:0]  NOP      = if_pkg::NOP,
  parameter logic [6:0]     B_OPC    = if_pkg::B_OPC
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          im_req,
  output logic [AW-1:0] im_addr,
  input  logic [IW-1:0] im_rdata,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [IW-1:0] id_instr,
  output logic [AW-1:0] id_pc,
  input  logic          br_taken,
  input  logic [AW-1:0] br_pc,
  input  logic [15:0]   br_offset,
  output logic [31:0]   perf_fetch,
  output logic [31:0]   perf_flush
);

  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = PW + 2;

  logic [AW-1:0] r_pc;
  logic          r_inflight;
  logic [AW-1:0] r_inflight_pc;

  logic [AW-1:0] w_pc_nxt;
  logic          w_pop;
  logic          w_resp;
  logic          w_local_b;
  logic          w_push;
  logic          w_issue;
  logic          w_full;
  logic          w_empty;
  logic [PW:0]   w_count;
  logic [CW-1:0] w_reserved;
  fq_entry_t     w_push_data;
  fq_entry_t     w_head;

  // A response is squashed by a redirect in the cycle it returns.
  assign w_pop      = ~w_empty & id_ready;
  assign w_resp     = r_inflight & ~br_taken;
  assign w_local_b  = w_resp & (im_rdata[31:25] == B_OPC);
  assign w_push     = w_resp & (~w_full | w_pop);

  // Slots already spoken for, counting the entry leaving this cycle as free.
  assign w_reserved = CW'(w_count) + CW'(r_inflight) - CW'(w_pop);
  assign w_issue    = rst_n & ~br_taken & ~w_local_b & (w_reserved < CW'(FQ_DEPTH));

  always_comb begin
    w_push_data       = '0;
    w_push_data.pc    = r_inflight_pc;
    w_push_data.instr = w_local_b ? NOP : im_rdata;
  end

  // External redirect has priority over a locally resolved B.
  always_comb begin
    w_pc_nxt = r_pc;
    if (br_taken)       w_pc_nxt = br_target(br_pc, br_offset);
    else if (w_local_b) w_pc_nxt = br_target(r_inflight_pc, im_rdata[15:0]);
    else if (w_issue)   w_pc_nxt = r_pc + AW'(4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_inflight <= w_issue;
      if (w_issue) r_inflight_pc <= im_addr;
    end
  end

  if_fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (br_taken),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  assign im_req   = w_issue;
  assign im_addr  = {r_pc[AW-1:2], 2'b00};
  assign id_valid = ~w_empty;
  assign id_instr = w_empty ? NOP : w_head.instr;
  assign id_pc    = w_empty ? '0  : w_head.pc;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetch <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_push)               r_perf_fetch <= r_perf_fetch + 32'd1;
      if (br_taken | w_local_b) r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign perf_fetch = r_perf_fetch;
  assign perf_flush = r_perf_flush;
`else
  assign perf_fetch = '0;
  assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: queue-based reference model checked every cycle plus directed literals.
module tb_if_fetch_unit;

  localparam logic [31:0] NOPW = 32'hC800_0000;
  localparam logic [31:0] BINS = 32'hC000_FFFC;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        br_taken;
  logic [31:0] br_pc;
  logic [15:0] br_offset;
  logic [31:0] perf_fetch;
  logic [31:0] perf_flush;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .im_rdata   (im_rdata),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .br_taken   (br_taken),
    .br_pc      (br_pc),
    .br_offset  (br_offset),
    .perf_fetch (perf_fetch),
    .perf_flush (perf_flush)
  );

  // Instruction memory contents: anything not overridden is a plain non-branch word.
  logic [31:0] imem [logic [31:0]];

  function automatic logic [31:0] memw(input logic [31:0] a);
    if (imem.exists(a)) return imem[a];
    return 32'h1000_0000 ^ a;
  endfunction

  function automatic logic [31:0] tgt(input logic [31:0] base, input logic [15:0] off);
    int s;
    s = int'($signed(off));
    return base + 32'(s * 4);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  ent_t        m_q[$];
  logic [31:0] m_pc, m_infl_pc, m_pf, m_pb;
  bit          m_infl;
  bit          p_pop, p_flush, p_push;
  ent_t        p_ent;
  logic [31:0] n_pc, n_infl_pc, n_pf, n_pb;
  bit          n_infl;

  // Observations
  int          cyc;
  int          first_valid;
  logic [31:0] act_iss[$];
  logic [31:0] act_del_pc[$];
  logic [31:0] act_del_instr[$];

  task automatic model_reset();
    m_q.delete();
    m_pc = 32'h0; m_infl_pc = 32'h0; m_infl = 1'b0; m_pf = 32'h0; m_pb = 32'h0;
  endtask

  task automatic model_check();
    int occ;
    bit v, pop, resp, isb, req;
    logic [31:0] e_pf, e_pb;
    occ  = m_q.size();
    v    = (occ > 0);
    pop  = v && id_ready;
    resp = m_infl && !br_taken;
    isb  = resp && (im_rdata[31:25] == 7'b1100000);
    req  = !br_taken && !isb && ((occ + (m_infl ? 1 : 0) - (pop ? 1 : 0)) < 2);
    chk("m_im_req",   64'(im_req),   64'(req));
    chk("m_im_addr",  64'(im_addr),  64'(m_pc));
    chk("m_id_valid", 64'(id_valid), 64'(v));
    chk("m_id_instr", 64'(id_instr), 64'(v ? m_q[0].instr : NOPW));
    chk("m_id_pc",    64'(id_pc),    64'(v ? m_q[0].pc : 32'h0));
`ifdef IF_PERF_CNT_EN
    e_pf = m_pf; e_pb = m_pb;
`else
    e_pf = 32'h0; e_pb = 32'h0;
`endif
    chk("m_perf_fetch", 64'(perf_fetch), 64'(e_pf));
    chk("m_perf_flush", 64'(perf_flush), 64'(e_pb));
    p_pop   = pop;
    p_flush = br_taken;
    p_push  = resp;
    p_ent   = '{pc: m_infl_pc, instr: (isb ? NOPW : im_rdata)};
    if (br_taken) n_pc = tgt(br_pc, br_offset);
    else if (isb) n_pc = tgt(m_infl_pc, im_rdata[15:0]);
    else if (req) n_pc = m_pc + 32'd4;
    else          n_pc = m_pc;
    n_infl    = req;
    n_infl_pc = m_pc;
    n_pf      = m_pf + (resp ? 32'd1 : 32'd0);
    n_pb      = m_pb + ((br_taken || isb) ? 32'd1 : 32'd0);
  endtask

  task automatic model_commit();
    if (p_pop && m_q.size() > 0) m_q.delete(0);
    if (p_flush) m_q.delete();
    if (p_push) m_q.push_back(p_ent);
    m_pc = n_pc; m_infl = n_infl; m_infl_pc = n_infl_pc; m_pf = n_pf; m_pb = n_pb;
  endtask

  // One clock: compare at the falling edge, advance model and memory after the rising edge.
  task automatic cycle();
    bit rq;
    logic [31:0] ad;
    @(negedge clk);
    model_check();
    rq = im_req;
    ad = im_addr;
    if (im_req) act_iss.push_back(im_addr);
    if (id_valid && id_ready) begin
      act_del_pc.push_back(id_pc);
      act_del_instr.push_back(id_instr);
    end
    if (id_valid && first_valid < 0) first_valid = cyc;
    @(posedge clk);
    #1;
    model_commit();
    if (rq) im_rdata = memw(ad);
    cyc++;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_im_req"},   64'(im_req),     64'(0));
    chk({tag, "_im_addr"},  64'(im_addr),    64'(0));
    chk({tag, "_id_valid"}, 64'(id_valid),   64'(0));
    chk({tag, "_id_instr"}, 64'(id_instr),   64'(NOPW));
    chk({tag, "_id_pc"},    64'(id_pc),      64'(0));
    chk({tag, "_pfetch"},   64'(perf_fetch), 64'(0));
    chk({tag, "_pflush"},   64'(perf_flush), 64'(0));
  endtask

  task automatic do_reset(input bit immediate);
    rst_n    = 1'b0;
    br_taken = 1'b0;
    #1;
    if (immediate) check_reset_vals("rst_imm");
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_vals("rst_hold");
    model_reset();
    act_iss.delete();
    act_del_pc.delete();
    act_del_instr.delete();
    cyc         = 0;
    first_valid = -1;
    rst_n       = 1'b1;
  endtask

  initial begin
    bit found;
    rst_n     = 1'b0;
    id_ready  = 1'b1;
    br_taken  = 1'b0;
    br_pc     = 32'h0;
    br_offset = 16'h0;
    im_rdata  = 32'h0;

    // 1: sequential fetch with ID always ready
    do_reset(1'b0);
    repeat (6) cycle();
    chk("s1_first_valid", 64'(first_valid), 64'(2));
    chk("s1_iss0", 64'(act_iss[0]), 64'h0);
    chk("s1_iss1", 64'(act_iss[1]), 64'h4);
    chk("s1_iss2", 64'(act_iss[2]), 64'h8);
    chk("s1_del0", 64'(act_del_pc[0]), 64'h0);
    chk("s1_del1", 64'(act_del_pc[1]), 64'h4);
    chk("s1_del2", 64'(act_del_pc[2]), 64'h8);
    chk("s1_ins0", 64'(act_del_instr[0]), 64'h1000_0000);

    // 2: ID stalled for 5 cycles, then released
    do_reset(1'b0);
    id_ready = 1'b0;
    repeat (5) cycle();
    chk("s2_n_issued", 64'(act_iss.size()), 64'(2));
    chk("s2_head_pc",  64'(id_pc), 64'h0);
    id_ready = 1'b1;
    repeat (5) cycle();
    chk("s2_del0", 64'(act_del_pc[0]), 64'h0);
    chk("s2_del1", 64'(act_del_pc[1]), 64'h4);
    chk("s2_del2", 64'(act_del_pc[2]), 64'h8);
    chk("s2_iss2", 64'(act_iss[2]), 64'h8);

    // 3: local B at 0x10 jumping back to 0x0
    imem[32'h10] = BINS;
    do_reset(1'b0);
    repeat (9) cycle();
    chk("s3_iss4", 64'(act_iss[4]), 64'h10);
    chk("s3_iss5", 64'(act_iss[5]), 64'h0);
    found = 1'b0;
    foreach (act_iss[i]) if (act_iss[i] == 32'h14) found = 1'b1;
    foreach (act_del_pc[i]) if (act_del_pc[i] == 32'h14) found = 1'b1;
    chk("s3_no_0x14", 64'(found), 64'(0));
    chk("s3_ndel", 64'(act_del_pc.size()), 64'(6));
    chk("s3_del4_pc", 64'(act_del_pc[4]), 64'h10);
    chk("s3_del4_nop", 64'(act_del_instr[4]), 64'(NOPW));
    chk("s3_del5_pc", 64'(act_del_pc[5]), 64'h0);
`ifdef IF_PERF_CNT_EN
    chk("s3_pflush", 64'(perf_flush), 64'(1));
    chk("s3_pfetch", 64'(perf_fetch), 64'(7));
`else
    chk("s3_pflush", 64'(perf_flush), 64'(0));
    chk("s3_pfetch", 64'(perf_fetch), 64'(0));
`endif

    // 4b: external redirect in the same cycle the B response returns
    do_reset(1'b0);
    repeat (5) cycle();
    br_taken = 1'b1; br_pc = 32'h100; br_offset = 16'h0001;
    cycle();
    br_taken = 1'b0;
    #1;
    chk("s4b_req",  64'(im_req),  64'(1));
    chk("s4b_addr", 64'(im_addr), 64'h104);
    repeat (3) cycle();
    chk("s4b_ndel", 64'(act_del_pc.size()), 64'(5));
    chk("s4b_del4", 64'(act_del_pc[4]), 64'h104);

    // 4: redirect while the queue is full, with a pop in the same cycle
    do_reset(1'b0);
    id_ready = 1'b0;
    repeat (3) cycle();
    chk("s4_full_valid", 64'(id_valid), 64'(1));
    chk("s4_full_pc",    64'(id_pc),    64'h0);
    id_ready = 1'b1;
    br_taken = 1'b1; br_pc = 32'h20; br_offset = 16'h0003;
    cycle();
    br_taken = 1'b0;
    #1;
    chk("s4_empty", 64'(id_valid), 64'(0));
    chk("s4_req",   64'(im_req),   64'(1));
    chk("s4_addr",  64'(im_addr),  64'h2C);
    repeat (3) cycle();
    chk("s4_ndel", 64'(act_del_pc.size()), 64'(2));
    chk("s4_del1", 64'(act_del_pc[1]), 64'h2C);

    // 5: PC wrap at the top of the address space, then reset with a fetch in flight
    do_reset(1'b0);
    br_taken = 1'b1; br_pc = 32'hFFFF_FFF8; br_offset = 16'h0001;
    cycle();
    br_taken = 1'b0;
    #1;
    chk("s5_addr_top", 64'(im_addr), 64'hFFFF_FFFC);
    cycle();
    #1;
    chk("s5_wrap_req",  64'(im_req),  64'(1));
    chk("s5_wrap_addr", 64'(im_addr), 64'h0);
    repeat (2) cycle();
    chk("s5_del0", 64'(act_del_pc[0]), 64'hFFFF_FFFC);
    do_reset(1'b1);
    repeat (3) cycle();
    chk("s5_post_first", 64'(first_valid), 64'(2));
    chk("s5_post_ndel",  64'(act_del_pc.size()), 64'(1));
    chk("s5_post_del0",  64'(act_del_pc[0]), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
